wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 89 ++++++++
 rtl/wb_queue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback queue: widths, entry type and rd-match helper.
package wb_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // x0 never counts as a hazard, so a zero source address never matches.
    function automatic logic rd_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular storage for pending writebacks; entries are also presented oldest-first for lookup.
// The data view of every entry exists only when WB_FWD_EN is defined.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int W     = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [REG_AW-1:0]              i_rd,
    input  logic [W-1:0]                   i_data,
    output logic [REG_AW-1:0]              o_head_rd,
    output logic [W-1:0]                   o_head_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [CW-1:0]                  o_count,
    output logic [DEPTH-1:0]               o_ent_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]   o_ent_rd
`ifdef WB_FWD_EN
    ,
    output logic [DEPTH-1:0][W-1:0]        o_ent_data
`endif
);

    logic [REG_AW-1:0] r_mem_rd   [DEPTH];
    logic [W-1:0]      r_mem_data [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign o_head_rd   = r_mem_rd[r_rd_ptr];
    assign o_head_data = r_mem_data[r_rd_ptr];

    // Pointers are AW bits wide, so DEPTH being a power of two makes wrap free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= i_rd;
            r_mem_data[r_wr_ptr] <= i_data;
        end
    end

    // Index 0 is the oldest entry; a higher index is younger.
    always_comb begin
        logic [AW-1:0] w_idx;
        w_idx       = '0;
        o_ent_valid = '0;
        o_ent_rd    = '0;
`ifdef WB_FWD_EN
        o_ent_data  = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            w_idx          = r_rd_ptr + AW'(i);
            o_ent_valid[i] = (CW'(i) < r_count);
            o_ent_rd[i]    = r_mem_rd[w_idx];
`ifdef WB_FWD_EN
            o_ent_data[i]  = r_mem_data[w_idx];
`endif
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: arbitrates load/ALU requests into a FIFO, drains one write per cycle
// into a registered register-file port, and reports source hazards. WB_FWD_EN adds forwarding data.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [wb_pkg::REG_AW-1:0]  alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [wb_pkg::REG_AW-1:0]  ld_rd,
    input  logic [XLEN-1:0]            ld_data,
    output logic                       rf_we,
    output logic [wb_pkg::REG_AW-1:0]  rf_rd,
    output logic [XLEN-1:0]            rf_wdata,
    input  logic [wb_pkg::REG_AW-1:0]  rs1,
    input  logic [wb_pkg::REG_AW-1:0]  rs2,
    output logic                       rs1_pend,
    output logic                       rs2_pend,
    output logic [$clog2(DEPTH):0]     count
`ifdef WB_FWD_EN
    ,
    output logic [XLEN-1:0]            fwd1_data,
    output logic [XLEN-1:0]            fwd2_data
`endif
);

    import wb_pkg::*;

    // A channel transfers at a posedge where its valid and ready are both high;
    // valid must not depend on ready, and ready is never asserted during reset.

    logic                          w_full;
    logic                          w_empty;
    logic                          w_ld_fire;
    logic                          w_alu_fire;
    logic                          w_push;
    logic [REG_AW-1:0]             w_push_rd;
    logic [XLEN-1:0]               w_push_data;
    logic [REG_AW-1:0]             w_head_rd;
    logic [XLEN-1:0]               w_head_data;
    logic [DEPTH-1:0]              w_ent_valid;
    logic [DEPTH-1:0][REG_AW-1:0]  w_ent_rd;
    logic                          w_rs1_hit;
    logic                          w_rs2_hit;
`ifdef WB_FWD_EN
    logic [DEPTH-1:0][XLEN-1:0]    w_ent_data;
`endif

    // Full is judged on the current count alone; a same-cycle pop gives no credit.
    assign ld_ready    = !reset && !w_full;
    assign alu_ready   = !reset && !w_full && !ld_valid;
    assign w_ld_fire   = ld_valid && ld_ready;
    assign w_alu_fire  = alu_valid && alu_ready;
    assign w_push_rd   = w_ld_fire ? ld_rd : alu_rd;
    assign w_push_data = w_ld_fire ? ld_data : alu_data;
    assign w_push      = (w_ld_fire && (ld_rd != '0)) || (w_alu_fire && (alu_rd != '0));

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (XLEN)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (!w_empty),
        .i_rd        (w_push_rd),
        .i_data      (w_push_data),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (count),
        .o_ent_valid (w_ent_valid),
        .o_ent_rd    (w_ent_rd)
`ifdef WB_FWD_EN
        ,
        .o_ent_data  (w_ent_data)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= !w_empty;
            if (!w_empty) begin
                rf_rd    <= w_head_rd;
                rf_wdata <= w_head_data;
            end
        end
    end

    always_comb begin
        w_rs1_hit = rf_we && rd_hit(rf_rd, rs1);
        w_rs2_hit = rf_we && rd_hit(rf_rd, rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i] && rd_hit(w_ent_rd[i], rs1)) w_rs1_hit = 1'b1;
            if (w_ent_valid[i] && rd_hit(w_ent_rd[i], rs2)) w_rs2_hit = 1'b1;
        end
    end

    assign rs1_pend = w_rs1_hit;
    assign rs2_pend = w_rs2_hit;

`ifdef WB_FWD_EN
    // Output register is the oldest candidate; younger FIFO matches override it in turn.
    always_comb begin
        fwd1_data = '0;
        fwd2_data = '0;
        if (rf_we && rd_hit(rf_rd, rs1)) fwd1_data = rf_wdata;
        if (rf_we && rd_hit(rf_rd, rs2)) fwd2_data = rf_wdata;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i] && rd_hit(w_ent_rd[i], rs1)) fwd1_data = w_ent_data[i];
            if (w_ent_valid[i] && rd_hit(w_ent_rd[i], rs2)) fwd2_data = w_ent_data[i];
        end
    end
`endif

endmodule
